sprite_compositor: RTL and testbench

//  Pipelined, parametrised pixel compositor between the game logic and vgac.

---
 rtl/vga_pkg.sv | 19 +
 rtl/spr_addr_gen.sv | 60 ++++++
 rtl/sprite_compositor.sv | 159 +++++++++++++++
 tb/tb_sprite_compositor.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA-side definitions: default widths, reserved colours and sprite orientation codes.
package vga_pkg;

    localparam int COL_W_DEF = 10;
    localparam int ROW_W_DEF = 9;
    localparam int CLR_W_DEF = 12;

    localparam logic [11:0] WALL_CLR_DEF = 12'hfff;
    localparam logic [11:0] BG_CLR_DEF   = 12'h000;
    localparam logic [11:0] KEY_CLR_DEF  = 12'h000;

    typedef enum logic [1:0] {
        ORI_T  = 2'b00,
        ORI_TF = 2'b01,
        ORI_N  = 2'b10,
        ORI_M  = 2'b11
    } ori_e;

endpackage

// File: rtl/spr_addr_gen.sv
// One sprite's S1 stage: hit test against the shadowed position and texel address
// generation for the four orientations; the address holds while the sprite is missed.
module spr_addr_gen
    import vga_pkg::*;
#(
    parameter int COL_W    = COL_W_DEF,
    parameter int ROW_W    = ROW_W_DEF,
    parameter int SPR_SIZE = 32,
    parameter int AW       = $clog2(SPR_SIZE * SPR_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] x,
    input  logic [ROW_W-1:0] y,
    input  logic [1:0]       orient,
    input  logic             vis,
    output logic             hit_q,
    output logic [AW-1:0]    addr_q
);
    localparam int LG = $clog2(SPR_SIZE);
    localparam logic [LG-1:0] M = LG'(SPR_SIZE - 1);

    logic [COL_W:0] dx;
    logic [ROW_W:0] dy;
    logic [LG-1:0]  u, v;
    logic           hit_n, hit_d;
    logic [AW-1:0]  addr_n, addr_d;

    always_comb begin
        // one extra bit keeps col<x negative instead of wrapping into the box
        dx    = {1'b0, col} - {1'b0, x};
        dy    = {1'b0, row} - {1'b0, y};
        u     = dx[LG-1:0];
        v     = dy[LG-1:0];
        hit_n = vis && (dx[COL_W:LG] == '0) && (dy[ROW_W:LG] == '0);
        case (ori_e'(orient))
            ORI_T:   addr_n = {u, v};
            ORI_TF:  addr_n = {u, M - v};
            ORI_N:   addr_n = {v, u};
            ORI_M:   addr_n = {v, M - u};
            default: addr_n = {v, u};
        endcase
        hit_d  = pix_en ? hit_n : hit_q;
        addr_d = (pix_en && hit_n) ? addr_n : addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite/wall/background compositor with frame-latched sprite shadows.
// Define SPR_COLLIDE_EN to build the sprite-0 collision accumulator behind collide.
module sprite_compositor
    import vga_pkg::*;
#(
    parameter int NUM_SPR  = 4,
    parameter int SPR_SIZE = 32,
    parameter int COL_W    = COL_W_DEF,
    parameter int ROW_W    = ROW_W_DEF,
    parameter int CLR_W    = CLR_W_DEF,
    parameter logic [CLR_W-1:0] KEY_CLR  = KEY_CLR_DEF,
    parameter logic [CLR_W-1:0] WALL_CLR = WALL_CLR_DEF,
    parameter logic [CLR_W-1:0] BG_CLR   = BG_CLR_DEF,
    localparam int AW = $clog2(SPR_SIZE * SPR_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_en,
    input  logic                     frame_start,
    input  logic [COL_W-1:0]         col_addr,
    input  logic [ROW_W-1:0]         row_addr,
    input  logic                     is_wall,
    input  logic [NUM_SPR*COL_W-1:0] spr_x,
    input  logic [NUM_SPR*ROW_W-1:0] spr_y,
    input  logic [NUM_SPR*2-1:0]     spr_orient,
    input  logic [NUM_SPR-1:0]       spr_vis,
    output logic [NUM_SPR*AW-1:0]    rom_addr,
    input  logic [NUM_SPR*CLR_W-1:0] rom_data,
    output logic [CLR_W-1:0]         pix_color,
    output logic                     pix_valid,
    output logic                     collide
);
    logic [NUM_SPR*COL_W-1:0] sh_x_q, sh_x_d;
    logic [NUM_SPR*ROW_W-1:0] sh_y_q, sh_y_d;
    logic [NUM_SPR*2-1:0]     sh_ori_q, sh_ori_d;
    logic [NUM_SPR-1:0]       sh_vis_q, sh_vis_d;

    logic [NUM_SPR-1:0] hit_q;
    logic               wall_q, wall_d;
    logic               s1_vld_q, s1_vld_d;
    logic [NUM_SPR-1:0] opq;
    logic [CLR_W-1:0]   sel_clr;
    logic [CLR_W-1:0]   pix_color_q, pix_color_d;
    logic               pix_valid_q, pix_valid_d;

    // Sprite state is latched only at frame start so a frame never tears.
    always_comb begin
        sh_x_d   = sh_x_q;
        sh_y_d   = sh_y_q;
        sh_ori_d = sh_ori_q;
        sh_vis_d = sh_vis_q;
        if (frame_start) begin
            sh_x_d   = spr_x;
            sh_y_d   = spr_y;
            sh_ori_d = spr_orient;
            sh_vis_d = spr_vis;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_x_q   <= '0;
            sh_y_q   <= '0;
            sh_ori_q <= '0;
            sh_vis_q <= '0;
        end else begin
            sh_x_q   <= sh_x_d;
            sh_y_q   <= sh_y_d;
            sh_ori_q <= sh_ori_d;
            sh_vis_q <= sh_vis_d;
        end
    end

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        spr_addr_gen #(
            .COL_W    (COL_W),
            .ROW_W    (ROW_W),
            .SPR_SIZE (SPR_SIZE),
            .AW       (AW)
        ) u_addr (
            .clk    (clk),
            .rst    (rst),
            .pix_en (pix_en),
            .col    (col_addr),
            .row    (row_addr),
            .x      (sh_x_q[i*COL_W +: COL_W]),
            .y      (sh_y_q[i*ROW_W +: ROW_W]),
            .orient (sh_ori_q[i*2 +: 2]),
            .vis    (sh_vis_q[i]),
            .hit_q  (hit_q[i]),
            .addr_q (rom_addr[i*AW +: AW])
        );
    end

    always_comb begin
        wall_d   = pix_en ? is_wall : wall_q;
        s1_vld_d = pix_en ? 1'b1 : s1_vld_q;
    end

    always_comb begin
        opq = '0;
        for (int i = 0; i < NUM_SPR; i++)
            opq[i] = hit_q[i] && (rom_data[i*CLR_W +: CLR_W] != KEY_CLR);
        sel_clr = BG_CLR;
        // walk from the lowest priority up so sprite 0 lands last and wins
        for (int i = NUM_SPR - 1; i >= 0; i--)
            if (opq[i]) sel_clr = rom_data[i*CLR_W +: CLR_W];
        if (wall_q) sel_clr = WALL_CLR;
        pix_color_d = pix_en ? sel_clr : pix_color_q;
        pix_valid_d = pix_en && s1_vld_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wall_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            pix_color_q <= BG_CLR;
            pix_valid_q <= 1'b0;
        end else begin
            wall_q      <= wall_d;
            s1_vld_q    <= s1_vld_d;
            pix_color_q <= pix_color_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign pix_color = pix_color_q;
    assign pix_valid = pix_valid_q;

`ifdef SPR_COLLIDE_EN
    logic acc_q, acc_d, collide_q, collide_d, hit_now;

    // A hit landing on the frame_start cycle seeds the new frame's accumulator.
    always_comb begin
        hit_now   = pix_en && opq[0] && (|opq[NUM_SPR-1:1]);
        acc_d     = acc_q | hit_now;
        collide_d = collide_q;
        if (frame_start) begin
            collide_d = acc_q;
            acc_d     = hit_now;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            collide_q <= collide_d;
        end
    end

    assign collide = collide_q;
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised self-checking bench for sprite_compositor against a geometric reference model.
module tb_sprite_compositor;

`ifdef SPR_COLLIDE_EN
    localparam bit COL_ON = 1'b1;
`else
    localparam bit COL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, pix_en, frame_start, is_wall;
    logic [9:0]  col_addr;
    logic [8:0]  row_addr;
    logic [39:0] spr_x;
    logic [35:0] spr_y;
    logic [7:0]  spr_orient;
    logic [3:0]  spr_vis;
    logic [39:0] rom_addr;
    logic [47:0] rom_data;
    logic [11:0] pix_color;
    logic        pix_valid, collide;

    int t_x[4], t_y[4], t_o[4];
    bit t_v[4];
    bit key0;

    int          n_cmp = 0;
    int          n_bad = 0;

    // reference model state
    int          sh_x[4], sh_y[4], sh_o[4];
    bit          sh_v[4];
    int          exp_addr[4];
    logic [11:0] exp_color, prev_color;
    bit          exp_valid, have_prev, prev_both, m_acc, exp_collide;

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input int i, input logic [9:0] a, input bit k0);
        if (k0 && i == 0) return 12'h000;
        if (a[4:0] == 5'h1f) return 12'h000;
        return {i[1:0], a};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_io
        assign spr_x[g*10 +: 10]     = t_x[g][9:0];
        assign spr_y[g*9 +: 9]       = t_y[g][8:0];
        assign spr_orient[g*2 +: 2]  = t_o[g][1:0];
        assign spr_vis[g]            = t_v[g];
        assign rom_data[g*12 +: 12]  = rom_f(g, rom_addr[g*10 +: 10], key0);
    end

    sprite_compositor dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .frame_start (frame_start),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .is_wall     (is_wall),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_orient  (spr_orient),
        .spr_vis     (spr_vis),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_color   (pix_color),
        .pix_valid   (pix_valid),
        .collide     (collide)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_o[i] = 0; sh_v[i] = 0; exp_addr[i] = 0;
        end
        exp_color = 12'h000; prev_color = 12'h000;
        exp_valid = 0; have_prev = 0; prev_both = 0; m_acc = 0; exp_collide = 0;
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int o, input bit v);
        t_x[i] = x; t_y[i] = y; t_o[i] = o; t_v[i] = v;
    endtask

    task automatic clear_spr();
        for (int i = 0; i < 4; i++) set_spr(i, 0, 0, 2, 0);
    endtask

    // One clock: drive, advance, then update the model's view of the outputs.
    task automatic cyc(input bit pe, input bit fs, input int col, input int row, input bit wall);
        bit          op[4];
        bit          found, hn;
        logic [11:0] c, t;
        int          dx, dy, a;
        pix_en = pe; frame_start = fs;
        col_addr = col[9:0]; row_addr = row[8:0]; is_wall = wall;
        @(posedge clk);
        hn = 0;
        if (pe) begin
            exp_valid = have_prev;
            exp_color = prev_color;
            hn        = prev_both;
            c = 12'h000; found = 0;
            for (int i = 0; i < 4; i++) begin
                op[i] = 0;
                dx = col - sh_x[i];
                dy = row - sh_y[i];
                if (sh_v[i] && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
                    case (sh_o[i])
                        0:       a = dx * 32 + dy;
                        1:       a = dx * 32 + (31 - dy);
                        2:       a = dy * 32 + dx;
                        default: a = dy * 32 + (31 - dx);
                    endcase
                    exp_addr[i] = a;
                    t = rom_f(i, a[9:0], key0);
                    op[i] = (t != 12'h000);
                    if (op[i] && !found) begin c = t; found = 1; end
                end
            end
            if (wall) c = 12'hfff;
            prev_color = c;
            prev_both  = op[0] && (op[1] || op[2] || op[3]);
            have_prev  = 1;
        end else begin
            exp_valid = 0;
        end
        if (fs) begin
            exp_collide = m_acc;
            m_acc = hn;
            for (int i = 0; i < 4; i++) begin
                sh_x[i] = t_x[i]; sh_y[i] = t_y[i]; sh_o[i] = t_o[i]; sh_v[i] = t_v[i];
            end
        end else if (hn) begin
            m_acc = 1;
        end
        #1;
    endtask

    task automatic new_frame();
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1; pix_en = 0; frame_start = 0; is_wall = 0; col_addr = '0; row_addr = '0; key0 = 0;
        clear_spr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pix_color !== 12'h000) begin n_bad++; $display("FAIL rst_color got %h want 000", pix_color); end
        n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", pix_valid); end
        n_cmp++; if (collide !== 1'b0) begin n_bad++; $display("FAIL rst_collide got %b want 0", collide); end
        n_cmp++; if (rom_addr !== 40'h0) begin n_bad++; $display("FAIL rst_rom_addr got %h want 0", rom_addr); end
        rst = 0;
    endtask

    task automatic test_basic();
        clear_spr();
        set_spr(0, 100, 50, 2, 1);
        new_frame();
        cyc(1, 0, 103, 52, 0);
        n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL first_beat_valid got %b want 0", pix_valid); end
        n_cmp++; if (rom_addr[9:0] !== 10'd67) begin n_bad++; $display("FAIL basic_addr got %0d want 67", rom_addr[9:0]); end
        cyc(1, 0, 0, 0, 0);
        n_cmp++; if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", pix_valid); end
        n_cmp++; if (pix_color !== 12'd67) begin n_bad++; $display("FAIL basic_color got %h want %h", pix_color, 12'd67); end
        n_cmp++; if (collide !== 1'b0) begin n_bad++; $display("FAIL basic_collide got %b want 0", collide); end
    endtask

    task automatic test_orient();
        int ori[3]  = '{3, 1, 0};
        int cols[3] = '{100, 100, 101};
        int want[3] = '{31, 31, 32};
        for (int k = 0; k < 3; k++) begin
            clear_spr();
            set_spr(0, 100, 50, ori[k], 1);
            new_frame();
            cyc(1, 0, cols[k], 50, 0);
            n_cmp++;
            if (rom_addr[9:0] !== want[k][9:0] || int'(rom_addr[9:0]) != exp_addr[0]) begin
                n_bad++; $display("FAIL orient%0d_addr got %0d want %0d", ori[k], rom_addr[9:0], want[k]);
            end
            cyc(1, 0, 0, 0, 0);
            n_cmp++; if (pix_color !== exp_color) begin n_bad++; $display("FAIL orient%0d_color got %h want %h", ori[k], pix_color, exp_color); end
        end
    endtask

    task automatic test_priority();
        clear_spr();
        set_spr(0, 200, 100, 2, 1);
        set_spr(1, 200, 100, 2, 1);
        key0 = 1;
        new_frame();
        cyc(1, 0, 205, 103, 0);
        cyc(1, 0, 205, 103, 1);
        n_cmp++; if (pix_color !== 12'h465 || pix_color !== exp_color) begin n_bad++; $display("FAIL prio_keyed got %h want 465", pix_color); end
        cyc(1, 0, 0, 0, 0);
        n_cmp++; if (pix_color !== 12'hfff) begin n_bad++; $display("FAIL prio_wall got %h want fff", pix_color); end
        key0 = 0;
    endtask

    task automatic test_shadow();
        int cl[32];
        clear_spr();
        set_spr(0, 300, 200, 2, 1);
        new_frame();
        t_x[0] = 400;
        cyc(1, 0, 305, 205, 0);
        cyc(1, 0, 405, 205, 0);
        n_cmp++; if (pix_color !== 12'h0a5) begin n_bad++; $display("FAIL shadow_old got %h want 0a5", pix_color); end
        cyc(1, 1, 305, 205, 0);
        n_cmp++; if (pix_color !== 12'h000) begin n_bad++; $display("FAIL shadow_new_miss got %h want 000", pix_color); end
        cyc(1, 0, 405, 205, 0);
        n_cmp++; if (pix_color !== 12'h0a5) begin n_bad++; $display("FAIL shadow_fs_beat got %h want 0a5", pix_color); end
        cyc(1, 0, 0, 0, 0);
        n_cmp++; if (pix_color !== 12'h0a5) begin n_bad++; $display("FAIL shadow_moved got %h want 0a5", pix_color); end
        // right-edge sprite must not wrap into low columns
        set_spr(0, 1020, 10, 2, 1);
        new_frame();
        for (int k = 0; k < 32; k++) cl[k] = (k < 4) ? 1020 + k : k - 4;
        for (int k = 0; k <= 32; k++) begin
            cyc(1, 0, (k < 32) ? cl[k] : 0, 11, 0);
            if (k > 0) begin
                n_cmp++;
                if (pix_color !== exp_color || (pix_color != 12'h000) !== (cl[k-1] >= 1020)) begin
                    n_bad++; $display("FAIL edge_col%0d got %h want %h", cl[k-1], pix_color, exp_color);
                end
            end
        end
    endtask

    task automatic test_gaps();
        int pc[40], pr[40];
        bit pw[40];
        logic [11:0] ref_clr[40];
        clear_spr();
        for (int i = 0; i < 4; i++)
            set_spr(i, 100 + $urandom_range(0, 60), 50 + $urandom_range(0, 40), $urandom_range(0, 3), 1);
        new_frame();
        for (int k = 0; k < 40; k++) begin
            pc[k] = 100 + $urandom_range(0, 100);
            pr[k] = 50 + $urandom_range(0, 80);
            pw[k] = ($urandom_range(0, 7) == 0);
        end
        for (int k = 0; k < 40; k++) begin
            cyc(1, 0, pc[k], pr[k], pw[k]);
            ref_clr[k] = prev_color;
            n_cmp++;
            if (pix_valid !== exp_valid || pix_color !== exp_color) begin
                n_bad++; $display("FAIL run_pix%0d got %b/%h want %b/%h", k, pix_valid, pix_color, exp_valid, exp_color);
            end
            n_cmp++;
            for (int i = 0; i < 4; i++)
                if (int'(rom_addr[i*10 +: 10]) != exp_addr[i]) begin
                    n_bad++; $display("FAIL run_addr%0d_s%0d got %0d want %0d", k, i, rom_addr[i*10 +: 10], exp_addr[i]);
                    break;
                end
        end
        for (int k = 0; k < 40; k++) begin
            cyc(1, 0, pc[k], pr[k], pw[k]);
            n_cmp++;
            if (pix_valid !== 1'b1 || pix_color !== exp_color || (k > 0 && pix_color !== ref_clr[k-1])) begin
                n_bad++; $display("FAIL gap_pix%0d got %b/%h want 1/%h", k, pix_valid, pix_color, exp_color);
            end
            repeat ((k == 20) ? 10 : 3) begin
                cyc(0, 0, $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 1));
                n_cmp++;
                if (pix_valid !== 1'b0 || pix_color !== exp_color) begin
                    n_bad++; $display("FAIL gap_idle%0d got %b/%h want 0/%h", k, pix_valid, pix_color, exp_color);
                end
            end
        end
    endtask

    task automatic test_midreset();
        clear_spr();
        set_spr(0, 100, 50, 2, 1);
        new_frame();
        cyc(1, 0, 103, 52, 0);
        cyc(1, 0, 103, 52, 0);
        rst = 1;
        model_reset();
        #1;
        n_cmp++; if (pix_valid !== 1'b0 || pix_color !== 12'h000 || rom_addr !== 40'h0) begin
            n_bad++; $display("FAIL midrst_flush got %b/%h/%h want 0/000/0", pix_valid, pix_color, rom_addr);
        end
        @(posedge clk); #1;
        rst = 0;
        cyc(1, 0, 103, 52, 0);
        n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_beat1 got %b want 0", pix_valid); end
        cyc(1, 0, 103, 52, 0);
        n_cmp++; if (pix_valid !== 1'b1 || pix_color !== 12'h000) begin n_bad++; $display("FAIL midrst_beat2 got %b/%h want 1/000", pix_valid, pix_color); end
        new_frame();
        cyc(1, 0, 103, 52, 0);
        cyc(1, 0, 0, 0, 0);
        n_cmp++; if (pix_color !== 12'd67) begin n_bad++; $display("FAIL midrst_reload got %h want 043", pix_color); end
    endtask

    task automatic test_collide();
        clear_spr();
        set_spr(0, 300, 100, 2, 1);
        set_spr(2, 300, 100, 2, 1);
        new_frame();
        cyc(1, 0, 303, 102, 0);
        cyc(1, 0, 0, 0, 0);
        n_cmp++; if (collide !== (COL_ON & exp_collide)) begin n_bad++; $display("FAIL coll_frameN got %b want %b", collide, COL_ON & exp_collide); end
        set_spr(2, 500, 100, 2, 1);
        new_frame();
        n_cmp++; if (collide !== COL_ON || collide !== (COL_ON & exp_collide)) begin n_bad++; $display("FAIL coll_set got %b want %b", collide, COL_ON); end
        cyc(1, 0, 303, 102, 0);
        cyc(1, 0, 0, 0, 0);
        n_cmp++; if (collide !== COL_ON) begin n_bad++; $display("FAIL coll_hold got %b want %b", collide, COL_ON); end
        new_frame();
        n_cmp++; if (collide !== 1'b0 || exp_collide !== 1'b0) begin n_bad++; $display("FAIL coll_clear got %b want 0", collide); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_orient();
        test_priority();
        test_shadow();
        test_gaps();
        test_midreset();
        test_collide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
